// File: rtl/wb_port_arb.sv
// wb_port_arb: shares the register-file write port between load returns and a FIFO-buffered execute stream
module wb_port_arb #(
    parameter int DEPTH    = 2,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [AW-1:0]          ex_waddr,
    input  logic [DW-1:0]          ex_wdata,
    output logic                   ex_ready,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_waddr,
    input  logic [DW-1:0]          ld_wdata,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    input  logic [AW-1:0]          chk_addr,
    output logic                   chk_hit,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] occ
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    mem_addr [DEPTH];
    logic [DW-1:0]    mem_data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wp, rp;
    logic             ex_acc, push, pop, sel_we, hit;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

    // ready looks only at the registered count, so a same-cycle pop never frees a slot early
    assign ex_ready = occ != (PW+1)'(DEPTH);
    assign stall    = !ex_ready;
    assign ex_acc   = ex_valid && ex_ready;
    assign push     = ex_acc && (ld_valid || occ != '0);
    assign pop      = !ld_valid && occ != '0;
    assign sel_we   = ld_valid || pop || ex_acc;
    assign sel_addr = ld_valid ? ld_waddr : pop ? mem_addr[rp] : ex_waddr;
    assign sel_data = ld_valid ? ld_wdata : pop ? mem_data[rp] : ex_wdata;

    always_comb begin
        hit = rf_we && rf_waddr == chk_addr;
        for (int i = 0; i < DEPTH; i++)
            hit = hit | (vld[i] && mem_addr[i] == chk_addr);
    end

    assign chk_hit = hit && !(ZERO_REG != 0 && chk_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wp       <= '0;
            rp       <= '0;
            vld      <= '0;
            occ      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            rf_we <= sel_we && !(ZERO_REG != 0 && sel_addr == '0);
            if (sel_we) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
            if (push) begin
                mem_addr[wp] <= ex_waddr;
                mem_data[wp] <= ex_wdata;
                vld[wp]      <= 1'b1;
                wp           <= wp + 1'b1;
            end
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= rp + 1'b1;
            end
            occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule
